// File: rtl/rob_multi.sv
// rtl/rob_multi.sv - parametrised reorder buffer with multi-port completion and multi-wide in-order retire
module rob_multi #(
  parameter int DEPTH      = 16,
  parameter int CMPL_PORTS = 2,
  parameter int RETIRE_W   = 2,
  parameter int PREG_W     = 7,
  parameter int PC_W       = 32,
  localparam int TAG_W     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write_en,
  input  logic [PREG_W-1:0]            pd_new_in,
  input  logic [PREG_W-1:0]            pd_old_in,
  input  logic [PC_W-1:0]              pc_in,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [CMPL_PORTS-1:0]        complete_in,
  input  logic [CMPL_PORTS*TAG_W-1:0]  rob_fu,
  input  logic                         mispredict,
  input  logic [TAG_W-1:0]             mispredict_tag,
  output logic [RETIRE_W-1:0]          retire_valid,
  output logic [RETIRE_W*TAG_W-1:0]    retire_tag,
  output logic [RETIRE_W*PREG_W-1:0]   retire_pd_old,
  output logic [RETIRE_W*PREG_W-1:0]   retire_pd_new,
  output logic [RETIRE_W*PC_W-1:0]     retire_pc,
  output logic [TAG_W:0]               count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = TAG_W + 1;
  localparam int KW    = $clog2(RETIRE_W + 1);

  logic [PTR_W-1:0]  head, tail;
  logic [DEPTH-1:0]  valid, done;
  logic [PREG_W-1:0] pd_new_mem [DEPTH];
  logic [PREG_W-1:0] pd_old_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem     [DEPTH];

  logic              alloc;
  logic              mp_live;
  logic [PTR_W-1:0]  mp_ext;
  logic [TAG_W-1:0]  mp_rel;
  logic [KW-1:0]     ret_k;
  logic              stop;
  logic [TAG_W-1:0]  slot_idx [RETIRE_W];
  logic [DEPTH-1:0]  flush;

  always_comb begin
    count     = tail - head;
    full      = (count == PTR_W'(DEPTH));
    empty     = (count == '0);
    alloc_tag = tail[TAG_W-1:0];
    alloc     = write_en && !full && !mispredict;
  end

  // Branch position relative to head decides which entries are younger.
  always_comb begin
    mp_live = mispredict && valid[mispredict_tag];
    mp_ext  = {(mispredict_tag >= head[TAG_W-1:0]) ? head[TAG_W] : ~head[TAG_W], mispredict_tag};
    mp_rel  = mispredict_tag - head[TAG_W-1:0];
    for (int j = 0; j < DEPTH; j++) begin
      flush[j] = mp_live && valid[j] && ((TAG_W'(j) - head[TAG_W-1:0]) > mp_rel);
    end
  end

  // Retire never passes a live mispredicted branch on the same edge.
  always_comb begin
    ret_k = '0;
    stop  = 1'b0;
    for (int s = 0; s < RETIRE_W; s++) begin
      slot_idx[s] = head[TAG_W-1:0] + TAG_W'(s);
      if (!stop && valid[slot_idx[s]] && done[slot_idx[s]] &&
          !(mp_live && (TAG_W'(s) > mp_rel))) begin
        ret_k = ret_k + KW'(1);
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head          <= '0;
      tail          <= '0;
      valid         <= '0;
      done          <= '0;
      retire_valid  <= '0;
      retire_tag    <= '0;
      retire_pd_old <= '0;
      retire_pd_new <= '0;
      retire_pc     <= '0;
    end else begin
      for (int i = 0; i < CMPL_PORTS; i++) begin
        if (complete_in[i] && valid[rob_fu[i*TAG_W +: TAG_W]]) begin
          done[rob_fu[i*TAG_W +: TAG_W]] <= 1'b1;
        end
      end
      for (int s = 0; s < RETIRE_W; s++) begin
        if (KW'(s) < ret_k) begin
          valid[slot_idx[s]] <= 1'b0;
          done[slot_idx[s]]  <= 1'b0;
        end
      end
      for (int j = 0; j < DEPTH; j++) begin
        if (flush[j]) begin
          valid[j] <= 1'b0;
          done[j]  <= 1'b0;
        end
      end
      if (alloc) begin
        valid[tail[TAG_W-1:0]] <= 1'b1;
        done[tail[TAG_W-1:0]]  <= 1'b0;
      end
      head <= head + PTR_W'(ret_k);
      if (mp_live) begin
        tail <= mp_ext + PTR_W'(1);
      end else if (alloc) begin
        tail <= tail + PTR_W'(1);
      end
      for (int s = 0; s < RETIRE_W; s++) begin
        retire_valid[s] <= (KW'(s) < ret_k);
        if (KW'(s) < ret_k) begin
          retire_tag[s*TAG_W +: TAG_W]     <= slot_idx[s];
          retire_pd_old[s*PREG_W +: PREG_W] <= pd_old_mem[slot_idx[s]];
          retire_pd_new[s*PREG_W +: PREG_W] <= pd_new_mem[slot_idx[s]];
          retire_pc[s*PC_W +: PC_W]         <= pc_mem[slot_idx[s]];
        end else begin
          retire_tag[s*TAG_W +: TAG_W]     <= '0;
          retire_pd_old[s*PREG_W +: PREG_W] <= '0;
          retire_pd_new[s*PREG_W +: PREG_W] <= '0;
          retire_pc[s*PC_W +: PC_W]         <= '0;
        end
      end
    end
  end

  // Payload needs no reset: it is only read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc) begin
      pd_new_mem[tail[TAG_W-1:0]] <= pd_new_in;
      pd_old_mem[tail[TAG_W-1:0]] <= pd_old_in;
      pc_mem[tail[TAG_W-1:0]]     <= pc_in;
    end
  end

endmodule
